vgachargen_apb_ctrl: RTL and testbench
======================================

// Module: vgachargen_apb_ctrl
// PURPOSE
// APB slave front-end for vgachargen. Decodes APB transfers onto the char map, colour map
// and char tiff memory ports. Hides the memories' 1-cycle read latency behind the APB access phase.
// Contains a hardware fill engine that writes one 32-bit word over a whole map (screen clear / recolour).
// Arbitrates memory ports between the fill engine and the APB; the fill engine has priority.
// PARAMETERS
// FILL_WORDS   600  words written per fill (2400 chars / 4 per word); range 1..1024
// ADDR_W       14   PADDR width in bits
// PORTS
// clk_i              in   1   system clock (vgachargen clk_i domain)
// rst_i              in   1   reset; asynchronous, active-low
// paddr_i            in   14  APB byte address
// psel_i             in   1   APB select
// penable_i          in   1   APB enable
// pwrite_i           in   1   APB write
// pwdata_i           in   32  APB write data
// pstrb_i            in   4   APB byte strobes
// prdata_o           out  32  APB read data
// pready_o           out  1   APB ready
// pslverr_o          out  1   APB error (constant 0 without VGACHARGEN_APB_ERR_EN)
// char_map_addr_o    out  10  char map word address
// char_map_we_o      out  1   char map write enable
// char_map_be_o      out  4   char map byte enables
// char_map_wdata_o   out  32  char map write data
// char_map_rdata_i   in   32  char map read data, valid 1 cycle after addr
// col_map_addr_o / col_map_we_o / col_map_be_o / col_map_wdata_o / col_map_rdata_i: as char map
// char_tiff_addr_o   out  10  char tiff word address
// char_tiff_we_o     out  1   char tiff write enable (no byte enables)
// char_tiff_wdata_o  out  32  char tiff write data
// char_tiff_rdata_i  in   32  char tiff read data, valid 1 cycle after addr
// fill_busy_o        out  1   fill engine active
// BEHAVIOUR
// - Map: 0x0000-0x0FFF char map, 0x1000-0x1FFF col map, 0x2000-0x2FFF char tiff; mem addr = paddr[11:2].
//   0x3000 CTRL (W: bit0 start, bit1 target 0=char 1=col; R: bit0 busy, bit1 target); 0x3004 FILL_DATA (R/W).
//   Other offsets: writes ignored, reads return 0. paddr[1:0] ignored.
// - FSM: IDLE, WAIT, ACCESS. Setup (psel & !penable) to mem region, fill idle: drive addr/we/be/wdata
//   combinationally for that cycle, -> ACCESS. Access cycle: pready=1, prdata=mem rdata_i (0 wait states).
// - Setup to mem region while fill busy: -> WAIT, pready=0, no mem strobe; when busy falls, issue mem
//   cycle next clk, then ACCESS. Register region (0x3xxx): never waits, pready=1 in first access cycle.
// - we strobe for exactly one cycle per write; be = pstrb. Tiff write only if pstrb==4'hF, else dropped.
// - Fill: CTRL write with bit0=1 while idle latches target, busy=1 next cycle; writes FILL_DATA to
//   word 0..FILL_WORDS-1, one per cycle, be=4'hF; busy=0 the cycle after last word. Start while busy ignored.
// - FILL_DATA write during fill affects next fill only (value latched at start).
// - Unselected mem ports: we=0, be=0, addr=0, wdata=0.
// - Reset (any time, incl. mid-fill/mid-transfer): FSM IDLE, counter 0, busy 0, CTRL/FILL_DATA 0,
//   prdata_o 0, pready_o 0, pslverr_o 0, all we/be 0. Aborted fill leaves remaining words untouched.
// CONFIGURATION
// VGACHARGEN_APB_ERR_EN defined: pslverr_o=1 with pready on unmapped offsets, tiff write with
//   pstrb!=4'hF, start while busy; prdata=0, no side effect. Undefined: pslverr_o tied 0, same drops silently.
// TESTING
// 1. Reset held 100 ns -> all outputs 0, fill_busy_o 0; release -> FSM IDLE.
// 2. Write 0x0008=0xDEADBEEF pstrb F -> char_map_addr_o=2, we=1, be=F one cycle; read 0x0008 -> 0xDEADBEEF, 0 waits.
// 3. Write 0x1004=0x11223344 pstrb 4'b0100 -> col_map be=4'b0100 addr=1; readback byte2=0x22, rest prior.
// 4. FILL_DATA=0x00410041, CTRL=0x1 -> 600 char map writes addr 0..599, busy 600 cycles; char read
//    issued mid-fill stalls until busy=0 and returns 0x00410041.
// 5. Write 0x2FFC=0xA5A5A5A5 pstrb F -> char_tiff_addr_o=1023; pstrb 0x3 write -> no we, data unchanged.
// 6. ERR_EN: read 0x3FF0 -> pslverr=1, prdata=0; reset asserted mid-fill at word 100 -> busy=0, words 101+ unchanged.

Source files
------------

// File: rtl/vgachargen_apb_ctrl_if.sv
// APB bus bundle between the vgachargen bus master and vgachargen_apb_ctrl.
interface vgachargen_apb_ctrl_if #(
   parameter int ADDR_W = 14
);
   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [31:0]       pwdata;
   logic [3:0]        pstrb;
   logic [31:0]       prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/vgachargen_apb_ctrl.sv
// APB slave front-end for vgachargen: char map / col map / char tiff ports plus a map fill engine.
// Define VGACHARGEN_APB_ERR_EN to report unmapped offsets and dropped accesses on pslverr.
module vgachargen_apb_ctrl #(
   parameter int FILL_WORDS = 600,
   parameter int ADDR_W     = 14
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   vgachargen_apb_ctrl_if.slave apb,
   output logic [9:0]           char_map_addr_o,
   output logic                 char_map_we_o,
   output logic [3:0]           char_map_be_o,
   output logic [31:0]          char_map_wdata_o,
   input  logic [31:0]          char_map_rdata_i,
   output logic [9:0]           col_map_addr_o,
   output logic                 col_map_we_o,
   output logic [3:0]           col_map_be_o,
   output logic [31:0]          col_map_wdata_o,
   input  logic [31:0]          col_map_rdata_i,
   output logic [9:0]           char_tiff_addr_o,
   output logic                 char_tiff_we_o,
   output logic [31:0]          char_tiff_wdata_o,
   input  logic [31:0]          char_tiff_rdata_i,
   output logic                 fill_busy_o
);
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
   typedef enum logic [1:0] {RGN_CHAR, RGN_COL, RGN_TIFF, RGN_REG} rgn_t;

   localparam logic [9:0] LAST_WORD = 10'(FILL_WORDS - 1);

   state_t      state;
   rgn_t        rgn;
   rgn_t        acc_rgn;
   logic        acc_rd;
   logic        pready_q;
   logic [31:0] reg_rdata_q;
   logic [31:0] fill_data;
   logic [31:0] fill_val;
   logic        ctrl_tgt;
   logic        fill_busy;
   logic [9:0]  fill_cnt;
   logic        setup;
   logic        enter_acc;
   logic        mem_go;
   logic        reg_ctrl;
   logic        reg_fdata;
   logic        tiff_ok;
   logic [9:0]  word_addr;
   logic        unused_paddr_lsb;

   assign rgn              = rgn_t'(apb.paddr[ADDR_W-1 -: 2]);
   assign word_addr        = apb.paddr[11:2];
   assign setup            = apb.psel & ~apb.penable;
   assign reg_ctrl         = (word_addr == 10'd0);
   assign reg_fdata        = (word_addr == 10'd1);
   assign tiff_ok          = (apb.pstrb == 4'hF);
   assign unused_paddr_lsb = ^apb.paddr[1:0];

   // Memory cycles are only launched while the fill engine is idle; register accesses never stall.
   assign mem_go    = !fill_busy && ((state == IDLE && setup && rgn != RGN_REG) || state == WAIT);
   assign enter_acc = mem_go || (state == IDLE && setup && rgn == RGN_REG);

`ifdef VGACHARGEN_APB_ERR_EN
   logic acc_err;
   logic pslverr_q;
   assign acc_err = (rgn == RGN_REG) ?
                    (!(reg_ctrl || reg_fdata) || (reg_ctrl && apb.pwrite && apb.pwdata[0] && fill_busy)) :
                    (rgn == RGN_TIFF && apb.pwrite && !tiff_ok);
   assign apb.pslverr = pslverr_q;
`else
   assign apb.pslverr = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         acc_rgn     <= RGN_CHAR;
         acc_rd      <= 1'b0;
         pready_q    <= 1'b0;
         reg_rdata_q <= '0;
         fill_data   <= '0;
         fill_val    <= '0;
         ctrl_tgt    <= 1'b0;
         fill_busy   <= 1'b0;
         fill_cnt    <= '0;
`ifdef VGACHARGEN_APB_ERR_EN
         pslverr_q   <= 1'b0;
`endif
      end else begin
         if (fill_busy) begin
            if (fill_cnt == LAST_WORD) fill_busy <= 1'b0;
            fill_cnt <= fill_cnt + 10'd1;
         end

         pready_q <= 1'b0;
`ifdef VGACHARGEN_APB_ERR_EN
         pslverr_q <= 1'b0;
`endif
         case (state)
            IDLE:    if (setup) state <= (rgn != RGN_REG && fill_busy) ? WAIT : ACCESS;
            WAIT:    if (!fill_busy) state <= ACCESS;
            default: state <= IDLE;
         endcase

         // Register side effects and read data are captured at the end of the setup cycle.
         if (enter_acc) begin
            pready_q    <= 1'b1;
            acc_rgn     <= rgn;
            acc_rd      <= !apb.pwrite;
            reg_rdata_q <= '0;
`ifdef VGACHARGEN_APB_ERR_EN
            pslverr_q   <= acc_err;
`endif
            if (rgn == RGN_REG) begin
               if (apb.pwrite) begin
                  if (reg_fdata) fill_data <= apb.pwdata;
                  if (reg_ctrl && !fill_busy) begin
                     ctrl_tgt <= apb.pwdata[1];
                     if (apb.pwdata[0]) begin
                        fill_busy <= 1'b1;
                        fill_cnt  <= '0;
                        fill_val  <= fill_data;
                     end
                  end
               end else if (reg_ctrl) begin
                  reg_rdata_q <= {30'd0, ctrl_tgt, fill_busy};
               end else if (reg_fdata) begin
                  reg_rdata_q <= fill_data;
               end
            end
         end
      end
   end

   always_comb begin
      apb.prdata = '0;
      if (state == ACCESS && acc_rd) begin
         case (acc_rgn)
            RGN_CHAR: apb.prdata = char_map_rdata_i;
            RGN_COL:  apb.prdata = col_map_rdata_i;
            RGN_TIFF: apb.prdata = char_tiff_rdata_i;
            default:  apb.prdata = reg_rdata_q;
         endcase
      end
   end

   always_comb begin
      char_map_addr_o   = '0;
      char_map_we_o     = 1'b0;
      char_map_be_o     = '0;
      char_map_wdata_o  = '0;
      col_map_addr_o    = '0;
      col_map_we_o      = 1'b0;
      col_map_be_o      = '0;
      col_map_wdata_o   = '0;
      char_tiff_addr_o  = '0;
      char_tiff_we_o    = 1'b0;
      char_tiff_wdata_o = '0;
      if (fill_busy) begin
         if (ctrl_tgt) begin
            col_map_addr_o   = fill_cnt;
            col_map_we_o     = 1'b1;
            col_map_be_o     = '1;
            col_map_wdata_o  = fill_val;
         end else begin
            char_map_addr_o  = fill_cnt;
            char_map_we_o    = 1'b1;
            char_map_be_o    = '1;
            char_map_wdata_o = fill_val;
         end
      end else if (mem_go) begin
         case (rgn)
            RGN_CHAR: begin
               char_map_addr_o  = word_addr;
               char_map_we_o    = apb.pwrite;
               char_map_be_o    = apb.pwrite ? apb.pstrb : 4'h0;
               char_map_wdata_o = apb.pwrite ? apb.pwdata : 32'h0;
            end
            RGN_COL: begin
               col_map_addr_o   = word_addr;
               col_map_we_o     = apb.pwrite;
               col_map_be_o     = apb.pwrite ? apb.pstrb : 4'h0;
               col_map_wdata_o  = apb.pwrite ? apb.pwdata : 32'h0;
            end
            RGN_TIFF: begin
               char_tiff_addr_o  = word_addr;
               char_tiff_we_o    = apb.pwrite & tiff_ok;
               char_tiff_wdata_o = (apb.pwrite & tiff_ok) ? apb.pwdata : 32'h0;
            end
            default: ;
         endcase
      end
   end

   assign apb.pready  = pready_q;
   assign fill_busy_o = fill_busy;
endmodule

// File: tb/tb_vgachargen_apb_ctrl.sv
// Randomized self-checking bench for vgachargen_apb_ctrl against a word-level memory/register model.
module tb_vgachargen_apb_ctrl;
   localparam int FILL_WORDS = 600;
   localparam int TMO        = 3000;
`ifdef VGACHARGEN_APB_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk_i;
   logic rst_i;
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   vgachargen_apb_ctrl_if #(.ADDR_W(14)) apb ();

   logic [9:0]  char_map_addr_o, col_map_addr_o, char_tiff_addr_o;
   logic        char_map_we_o, col_map_we_o, char_tiff_we_o;
   logic [3:0]  char_map_be_o, col_map_be_o;
   logic [31:0] char_map_wdata_o, col_map_wdata_o, char_tiff_wdata_o;
   logic [31:0] char_map_rdata_i, col_map_rdata_i, char_tiff_rdata_i;
   logic        fill_busy_o;

   vgachargen_apb_ctrl #(.FILL_WORDS(FILL_WORDS), .ADDR_W(14)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .apb(apb),
      .char_map_addr_o(char_map_addr_o), .char_map_we_o(char_map_we_o),
      .char_map_be_o(char_map_be_o), .char_map_wdata_o(char_map_wdata_o),
      .char_map_rdata_i(char_map_rdata_i),
      .col_map_addr_o(col_map_addr_o), .col_map_we_o(col_map_we_o),
      .col_map_be_o(col_map_be_o), .col_map_wdata_o(col_map_wdata_o),
      .col_map_rdata_i(col_map_rdata_i),
      .char_tiff_addr_o(char_tiff_addr_o), .char_tiff_we_o(char_tiff_we_o),
      .char_tiff_wdata_o(char_tiff_wdata_o), .char_tiff_rdata_i(char_tiff_rdata_i),
      .fill_busy_o(fill_busy_o)
   );

   function automatic logic [31:0] init_word(input int rg, input int i);
      return 32'h5A00_0000 + 32'(rg << 20) + 32'(i) * 32'h0001_0003;
   endfunction

   // Synchronous-read memories sitting behind the DUT ports, plus write monitors.
   logic [31:0] char_mem [1024];
   logic [31:0] col_mem  [1024];
   logic [31:0] tiff_mem [1024];
   bit          mem_init = 1'b0;
   int          char_we_n = 0, col_we_n = 0, tiff_we_n = 0, busy_cyc = 0;
   logic [9:0]  last_char_addr = '0, last_col_addr = '0, last_tiff_addr = '0;
   logic [3:0]  last_char_be = '0, last_col_be = '0;
   int          char_wr_q [$];

   always @(posedge clk_i) begin
      if (!mem_init) begin
         for (int i = 0; i < 1024; i++) begin
            char_mem[i] <= init_word(0, i);
            col_mem[i]  <= init_word(1, i);
            tiff_mem[i] <= init_word(2, i);
         end
         mem_init <= 1'b1;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (char_map_we_o && char_map_be_o[b]) char_mem[char_map_addr_o][8*b +: 8] <= char_map_wdata_o[8*b +: 8];
            if (col_map_we_o && col_map_be_o[b])   col_mem[col_map_addr_o][8*b +: 8]   <= col_map_wdata_o[8*b +: 8];
         end
         if (char_tiff_we_o) tiff_mem[char_tiff_addr_o] <= char_tiff_wdata_o;
      end
      char_map_rdata_i  <= char_mem[char_map_addr_o];
      col_map_rdata_i   <= col_mem[col_map_addr_o];
      char_tiff_rdata_i <= tiff_mem[char_tiff_addr_o];
   end

   always @(posedge clk_i) begin
      if (fill_busy_o === 1'b1) busy_cyc <= busy_cyc + 1;
      if (char_map_we_o) begin
         char_we_n      <= char_we_n + 1;
         last_char_addr <= char_map_addr_o;
         last_char_be   <= char_map_be_o;
         char_wr_q.push_back(int'(char_map_addr_o));
      end
      if (col_map_we_o) begin
         col_we_n      <= col_we_n + 1;
         last_col_addr <= col_map_addr_o;
         last_col_be   <= col_map_be_o;
      end
      if (char_tiff_we_o) begin
         tiff_we_n      <= tiff_we_n + 1;
         last_tiff_addr <= char_tiff_addr_o;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference model: whole-word memory images and register values.
   logic [31:0] exp_char [1024];
   logic [31:0] exp_col  [1024];
   logic [31:0] exp_tiff [1024];
   logic [31:0] m_fdata, m_fval;
   bit          m_tgt, m_ftgt, m_busy;

   function automatic bit model_err(input int a, input bit wr, input logic [31:0] d, input logic [3:0] s);
      int rg  = a / 4096;
      int off = (a % 4096) / 4;
      if (!ERR_EN) return 1'b0;
      if (rg == 3) return !(off == 0 || off == 1) || (wr && off == 0 && d[0] && m_busy);
      return rg == 2 && wr && s != 4'hF;
   endfunction

   function automatic logic [31:0] model_read(input int a);
      int rg  = a / 4096;
      int off = (a % 4096) / 4;
      case (rg)
         0: return exp_char[off];
         1: return exp_col[off];
         2: return exp_tiff[off];
         default: begin
            if (off == 0) return {30'd0, m_tgt, m_busy};
            if (off == 1) return m_fdata;
            return 32'h0;
         end
      endcase
   endfunction

   task automatic model_write(input int a, input logic [31:0] d, input logic [3:0] s, output bit started);
      int rg  = a / 4096;
      int off = (a % 4096) / 4;
      started = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if (rg == 0 && s[b]) exp_char[off][8*b +: 8] = d[8*b +: 8];
         if (rg == 1 && s[b]) exp_col[off][8*b +: 8]  = d[8*b +: 8];
      end
      if (rg == 2 && s == 4'hF) exp_tiff[off] = d;
      if (rg == 3 && off == 1) m_fdata = d;
      if (rg == 3 && off == 0 && !m_busy) begin
         m_tgt = d[1];
         if (d[0]) begin
            m_busy  = 1'b1;
            m_fval  = m_fdata;
            m_ftgt  = d[1];
            started = 1'b1;
         end
      end
   endtask

   task automatic model_fill(input int n);
      for (int i = 0; i < n; i++) begin
         if (m_ftgt) exp_col[i] = m_fval;
         else        exp_char[i] = m_fval;
      end
   endtask

   task automatic apb_xfer(input logic [13:0] a, input logic wr, input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rd, output logic err, output int waits);
      apb.paddr   = a;
      apb.psel    = 1'b1;
      apb.penable = 1'b0;
      apb.pwrite  = wr;
      apb.pwdata  = d;
      apb.pstrb   = s;
      @(posedge clk_i); #1;
      apb.penable = 1'b1;
      waits = 0;
      while (apb.pready !== 1'b1 && waits < TMO) begin
         @(posedge clk_i); #1;
         waits++;
      end
      if (waits >= TMO) check_eq("apb_timeout", 32'(waits), 32'(0));
      rd  = apb.prdata;
      err = apb.pslverr;
      @(posedge clk_i); #1;
      apb.psel    = 1'b0;
      apb.penable = 1'b0;
      apb.pwrite  = 1'b0;
   endtask

   task automatic do_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] rd;
      logic        err;
      int          w;
      bit          exp_err, started;
      exp_err = model_err(int'(a), 1'b1, d, s);
      model_write(int'(a), d, s, started);
      apb_xfer(a, 1'b1, d, s, rd, err, w);
      check_eq($sformatf("wr_err_%04h", a), 32'(err), 32'(exp_err));
      if (started) model_fill(FILL_WORDS);
   endtask

   task automatic do_read(input logic [13:0] a, output int w);
      logic [31:0] rd, exp_d;
      logic        err;
      bit          exp_err;
      exp_err = model_err(int'(a), 1'b0, 32'h0, 4'h0);
      exp_d   = model_read(int'(a));
      apb_xfer(a, 1'b0, 32'h0, 4'h0, rd, err, w);
      check_eq($sformatf("rd_data_%04h", a), rd, exp_d);
      check_eq($sformatf("rd_err_%04h", a), 32'(err), 32'(exp_err));
   endtask

   task automatic wait_fill_done();
      int c = 0;
      while (fill_busy_o !== 1'b0 && c < TMO) begin
         @(posedge clk_i); #1;
         c++;
      end
      if (c >= TMO) check_eq("fill_done_timeout", 32'(c), 32'(0));
      m_busy = 1'b0;
   endtask

   task automatic compare_mems(input string tag);
      int dc = 0, dl = 0, dt = 0;
      for (int i = 0; i < 1024; i++) begin
         if (char_mem[i] !== exp_char[i]) dc++;
         if (col_mem[i]  !== exp_col[i])  dl++;
         if (tiff_mem[i] !== exp_tiff[i]) dt++;
      end
      check_eq({tag, "_char_words_diff"}, 32'(dc), 32'(0));
      check_eq({tag, "_col_words_diff"},  32'(dl), 32'(0));
      check_eq({tag, "_tiff_words_diff"}, 32'(dt), 32'(0));
   endtask

   task automatic check_ports_idle(input string tag);
      check_eq({tag, "_prdata"}, apb.prdata, 32'h0);
      check_eq({tag, "_pready_pslverr_busy"}, 32'({apb.pready, apb.pslverr, fill_busy_o}), 32'h0);
      check_eq({tag, "_we_be"}, 32'({char_map_we_o, char_map_be_o, col_map_we_o, col_map_be_o, char_tiff_we_o}), 32'h0);
      check_eq({tag, "_addr"}, 32'({char_map_addr_o, col_map_addr_o, char_tiff_addr_o}), 32'h0);
      check_eq({tag, "_wdata"}, char_map_wdata_o | col_map_wdata_o | char_tiff_wdata_o, 32'h0);
   endtask

   initial begin
      logic [31:0] rd, d;
      logic        err;
      logic [3:0]  s;
      int          w, n0, b0, q0, bad, kind, word, a, fills_left;
      bit          wr;

      apb.paddr = '0; apb.psel = 1'b0; apb.penable = 1'b0;
      apb.pwrite = 1'b0; apb.pwdata = '0; apb.pstrb = '0;
      rst_i = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         exp_char[i] = init_word(0, i);
         exp_col[i]  = init_word(1, i);
         exp_tiff[i] = init_word(2, i);
      end
      m_fdata = '0; m_fval = '0; m_tgt = 1'b0; m_ftgt = 1'b0; m_busy = 1'b0;

      // Reset held for ten clocks (100 time units)
      repeat (10) @(posedge clk_i);
      #1;
      check_ports_idle("reset");
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check_ports_idle("post_reset");

      // Full-word char map write and zero-wait readback
      n0 = char_we_n;
      do_write(14'h0008, 32'hDEADBEEF, 4'hF);
      check_eq("t2_char_we_cycles", 32'(char_we_n - n0), 32'd1);
      check_eq("t2_char_addr", 32'(last_char_addr), 32'd2);
      check_eq("t2_char_be", 32'(last_char_be), 32'hF);
      do_read(14'h0008, w);
      check_eq("t2_read_waits", 32'(w), 32'd0);

      // Single-byte col map write
      n0 = col_we_n;
      do_write(14'h1004, 32'h11223344, 4'b0100);
      check_eq("t3_col_we_cycles", 32'(col_we_n - n0), 32'd1);
      check_eq("t3_col_addr", 32'(last_col_addr), 32'd1);
      check_eq("t3_col_be", 32'(last_col_be), 32'h4);
      do_read(14'h1004, w);

      // Char map fill with a stalled read, a busy-time FILL_DATA write and an ignored restart
      do_write(14'h3004, 32'h00410041, 4'hF);
      b0 = busy_cyc;
      q0 = char_wr_q.size();
      do_write(14'h3000, 32'h1, 4'hF);
      do_read(14'h3000, w);
      do_write(14'h3004, 32'h12345678, 4'hF);
      do_write(14'h3000, 32'h3, 4'hF);
      repeat (40) @(posedge clk_i);
      #1;
      do_read(14'(599 * 4), w);
      check_eq("t4_read_stalled", 32'(w > 0), 32'd1);
      wait_fill_done();
      check_eq("t4_busy_cycles", 32'(busy_cyc - b0), 32'(FILL_WORDS));
      check_eq("t4_fill_writes", 32'(char_wr_q.size() - q0), 32'(FILL_WORDS));
      bad = 0;
      for (int i = 0; i < FILL_WORDS && q0 + i < char_wr_q.size(); i++)
         if (char_wr_q[q0 + i] != i) bad++;
      check_eq("t4_fill_order", 32'(bad), 32'd0);
      compare_mems("t4");
      do_read(14'h3004, w);
      do_read(14'h3000, w);

      // Char tiff: full write at the top word, partial-strobe write dropped
      n0 = tiff_we_n;
      do_write(14'h2FFC, 32'hA5A5A5A5, 4'hF);
      check_eq("t5_tiff_we_cycles", 32'(tiff_we_n - n0), 32'd1);
      check_eq("t5_tiff_addr", 32'(last_tiff_addr), 32'd1023);
      do_read(14'h2FFC, w);
      n0 = tiff_we_n;
      do_write(14'h2FFC, 32'h5A5A5A5A, 4'h3);
      check_eq("t5_tiff_partial_we", 32'(tiff_we_n - n0), 32'd0);
      do_read(14'h2FFC, w);

      // Unmapped register read, then reset in the middle of a fill
      do_read(14'h3FF0, w);
      do_write(14'h3004, 32'hC0DEC0DE, 4'hF);
      apb_xfer(14'h3000, 1'b1, 32'h1, 4'hF, rd, err, w);
      m_fval = m_fdata;
      m_ftgt = 1'b0;
      w = 0;
      while (!(char_map_we_o === 1'b1 && char_map_addr_o == 10'd100) && w < TMO) begin
         @(negedge clk_i);
         w++;
      end
      if (w >= TMO) check_eq("t6_word100_timeout", 32'(w), 32'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      #1;
      check_ports_idle("t6_reset");
      model_fill(101);
      m_fdata = '0; m_tgt = 1'b0; m_busy = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      compare_mems("t6");
      do_read(14'h3000, w);
      do_read(14'h3004, w);

      // Randomized traffic over all regions with occasional fills
      fills_left = 2;
      for (int k = 0; k < 160; k++) begin
         kind = int'($urandom_range(0, 9));
         word = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15)) : int'($urandom_range(1008, 1023));
         a    = word * 4 + int'($urandom_range(0, 3));
         wr   = ($urandom_range(0, 1) == 1);
         d    = $urandom;
         s    = 4'($urandom_range(0, 15));
         case (kind)
            0, 1, 2: ;
            3, 4:    a = a + 32'h1000;
            5, 6: begin
               a = a + 32'h2000;
               if ($urandom_range(0, 1) == 1) s = 4'hF;
            end
            7:       a = 32'h3004 + (a % 4);
            8: begin
               a = 32'h3000 + (a % 4);
               if (fills_left > 0 && $urandom_range(0, 3) == 0 && wr) begin
                  d[0] = 1'b1;
                  fills_left--;
               end else begin
                  d[0] = 1'b0;
               end
            end
            default: a = 32'h3000 + int'($urandom_range(2, 1023)) * 4 + (a % 4);
         endcase
         if (wr) do_write(14'(a), d, s);
         else    do_read(14'(a), w);
         if (m_busy) wait_fill_done();
      end
      compare_mems("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
